// File: rtl/whack_pkg.sv
// Shared encodings for the whack-a-mole engine: game states, mode codes,
// mole-rate divisors and the placement LFSR polynomial.
// Pure declarations; no clocked logic, no backpressure.
package whack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_OVER = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_SLOW = 2'b01,
        MODE_MED  = 2'b10,
        MODE_FAST = 2'b11
    } mode_t;

    // Moles per second for each playable mode
    localparam int DIV_SLOW = 1;
    localparam int DIV_MED  = 2;
    localparam int DIV_FAST = 5;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One left shift of the placement LFSR, feedback from the tapped bits
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

    // Tick period in clocks for a rate divisor, never below one clock
    function automatic int rate_period(input int clk_hz, input int div);
        int p;
        p = clk_hz / div;
        return (p < 1) ? 1 : p;
    endfunction

endpackage

// File: rtl/whack_game_ctrl_if.sv
// Bundles the game controls, switches and display-facing outputs.
// Plain wires; latency is whatever the attached modules impose.
// No handshake: inputs are sampled every cycle, outputs are level signals.
interface whack_game_ctrl_if #(
    parameter int N_MOLES = 16
);
    logic [1:0]         mode_i;
    logic               start_i;
    logic [N_MOLES-1:0] switches_i;
    logic [N_MOLES-1:0] moles_o;
    logic [13:0]        score_o;
    logic [7:0]         time_left_o;
    logic [1:0]         state_o;
    logic               hit_o;
    logic               miss_o;

    // Player / board side: drives controls, watches the game
    modport master (
        output mode_i, start_i, switches_i,
        input  moles_o, score_o, time_left_o, state_o, hit_o, miss_o
    );

    // Game engine side
    modport slave (
        input  mode_i, start_i, switches_i,
        output moles_o, score_o, time_left_o, state_o, hit_o, miss_o
    );
endinterface

// File: rtl/tick_gen.sv
// Modulo counter emitting a one-cycle tick every 'period' clocks.
// Tick is asserted during the last count; first tick one full period after clr/reset.
// No backpressure; a new period is adopted only at a wrap or a clear.
module tick_gen #(
    parameter int CNT_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [CNT_W-1:0] period,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] last;

    // A zero period behaves like a period of one (tick every cycle)
    assign last = (period_q == '0) ? '0 : period_q - CNT_W'(1);
    assign tick = (cnt == last);

    // Count up, wrap on the last count and latch the period for the next lap
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt      <= '0;
            period_q <= period;
        end else if (tick) begin
            cnt      <= '0;
            period_q <= period;
        end else begin
            cnt      <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/whack_game_ctrl.sv
// Whack-a-mole engine: tick generation, IDLE/RUN/OVER FSM, mole placement, scoring.
// All outputs registered; a whack shows on hit_o/miss_o one cycle after the toggle.
// No backpressure: inputs are sampled every cycle and nothing is ever stalled.
module whack_game_ctrl
    import whack_pkg::*;
#(
    parameter int          N_MOLES      = 16,
    parameter int          CLK_HZ       = 100000000,
    parameter int          GAME_SECONDS = 60,
    parameter int          SCORE_MAX    = 9999,
    parameter int          PENALTY      = 1,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input logic               clock_i,
    input logic               reset_i,
    whack_game_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(CLK_HZ + 1);
    localparam int IDX_W = $clog2(N_MOLES);

    localparam logic [CNT_W-1:0] PER_SEC  = CNT_W'(rate_period(CLK_HZ, DIV_SLOW));
    localparam logic [CNT_W-1:0] PER_SLOW = CNT_W'(rate_period(CLK_HZ, DIV_SLOW));
    localparam logic [CNT_W-1:0] PER_MED  = CNT_W'(rate_period(CLK_HZ, DIV_MED));
    localparam logic [CNT_W-1:0] PER_FAST = CNT_W'(rate_period(CLK_HZ, DIV_FAST));

    localparam logic [7:0]  GS8    = 8'(GAME_SECONDS);
    localparam logic [13:0] SMAX14 = 14'(SCORE_MAX);
    localparam logic [N_MOLES-1:0] ONE_MOLE = N_MOLES'(1);

    if (!(N_MOLES == 4 || N_MOLES == 8 || N_MOLES == 16)) begin : g_bad_n_moles
        $error("whack_game_ctrl: N_MOLES must be 4, 8 or 16");
    end

    state_t             state_q;
    logic [N_MOLES-1:0] moles_q;
    logic [N_MOLES-1:0] prev_sw;
    logic [13:0]        score_q;
    logic [7:0]         time_q;
    logic               hit_q;
    logic               miss_q;
    logic [15:0]        lfsr_q;

    logic [15:0]        lfsr_nxt;
    logic [N_MOLES-1:0] mole_onehot;
    logic [N_MOLES-1:0] toggle;
    logic               hit_now;
    logic               miss_now;
    logic               start_ok;
    logic               enter_run;
    logic               mode_off;
    logic [13:0]        score_inc;
    logic [13:0]        score_dec;
    logic [CNT_W-1:0]   mole_period;
    logic               sec_tick;
    logic               mole_tick;

    // Either switch direction counts as a whack; a lit-mole toggle beats any misses
    assign toggle   = bus.switches_i ^ prev_sw;
    assign hit_now  = |(toggle & moles_q);
    assign miss_now = !hit_now && |(toggle & ~moles_q);

    assign mode_off  = (bus.mode_i == MODE_OFF);
    assign start_ok  = bus.start_i && !mode_off;
    assign enter_run = start_ok && (state_q != ST_RUN);

    assign score_inc = (score_q >= SMAX14) ? SMAX14 : score_q + 14'd1;
    assign score_dec = (score_q == '0) ? '0 : score_q - 14'd1;

    assign lfsr_nxt    = lfsr_next(lfsr_q);
    assign mole_onehot = ONE_MOLE << lfsr_nxt[IDX_W-1:0];

    // Mole period follows the selected mode; the tick counter adopts it at its next wrap
    always_comb begin
        mole_period = PER_SLOW;
        case (bus.mode_i)
            MODE_MED:  mole_period = PER_MED;
            MODE_FAST: mole_period = PER_FAST;
            default:   mole_period = PER_SLOW;
        endcase
    end

    tick_gen #(.CNT_W(CNT_W)) u_sec_tick (
        .clk    (clock_i),
        .rst    (reset_i),
        .clr    (enter_run),
        .period (PER_SEC),
        .tick   (sec_tick)
    );

    tick_gen #(.CNT_W(CNT_W)) u_mole_tick (
        .clk    (clock_i),
        .rst    (reset_i),
        .clr    (enter_run),
        .period (mole_period),
        .tick   (mole_tick)
    );

    // Game FSM with registered outputs, placement LFSR and switch history
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            moles_q <= '0;
            score_q <= '0;
            time_q  <= GS8;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            lfsr_q  <= LFSR_SEED;
            prev_sw <= bus.switches_i;
        end else begin
            prev_sw <= bus.switches_i;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    moles_q <= '0;
                    time_q  <= GS8;
                    if (start_ok) begin
                        state_q <= ST_RUN;
                        score_q <= '0;
                    end
                end

                ST_RUN: begin
                    if (mode_off) begin
                        // Abort keeps the score on display for the player
                        state_q <= ST_IDLE;
                        moles_q <= '0;
                        time_q  <= GS8;
                    end else begin
                        hit_q  <= hit_now;
                        miss_q <= miss_now;
                        if (hit_now) begin
                            score_q <= score_inc;
                        end else if (miss_now && PENALTY != 0) begin
                            score_q <= score_dec;
                        end
                        // A new mole wins over clearing the one just hit
                        if (mole_tick) begin
                            lfsr_q  <= lfsr_nxt;
                            moles_q <= mole_onehot;
                        end else if (hit_now) begin
                            moles_q <= '0;
                        end
                        if (sec_tick) begin
                            time_q <= time_q - 8'd1;
                            if (time_q == 8'd1) begin
                                state_q <= ST_OVER;
                                moles_q <= '0;
                            end
                        end
                    end
                end

                ST_OVER: begin
                    moles_q <= '0;
                    time_q  <= '0;
                    if (mode_off) begin
                        state_q <= ST_IDLE;
                        time_q  <= GS8;
                    end else if (start_ok) begin
                        state_q <= ST_RUN;
                        score_q <= '0;
                        time_q  <= GS8;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    moles_q <= '0;
                    time_q  <= GS8;
                end
            endcase
        end
    end

    assign bus.moles_o     = moles_q;
    assign bus.score_o     = score_q;
    assign bus.time_left_o = time_q;
    assign bus.state_o     = state_q;
    assign bus.hit_o       = hit_q;
    assign bus.miss_o      = miss_q;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Bench for whack_game_ctrl: cycle model of the game rules plus literal spot checks.
// Inputs driven on the falling edge, outputs compared on the falling edge.
// No backpressure in the design; every wait on the design is cycle-bounded.
module tb_whack_game_ctrl;

    localparam int          N    = 8;
    localparam int          CLK  = 10;
    localparam int          GS   = 6;
    localparam int          SMAX = 3;
    localparam int          PEN  = 1;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    whack_game_ctrl_if #(.N_MOLES(N)) bus ();

    whack_game_ctrl #(
        .N_MOLES(N), .CLK_HZ(CLK), .GAME_SECONDS(GS),
        .SCORE_MAX(SMAX), .PENALTY(PEN), .LFSR_SEED(SEED)
    ) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the game rules ----------------
    // m_state: 0 idle, 1 running, 2 over
    int          m_state, m_score, m_time;
    logic [N-1:0] m_moles, m_prev;
    logic [15:0] m_lfsr;
    bit          m_hit, m_miss, m_valid = 0;
    int          sec_n, mole_n, mole_per;

    function automatic int per_of(input logic [1:0] md);
        int p;
        case (md)
            2'd2:    p = CLK / 2;
            2'd3:    p = CLK / 5;
            default: p = CLK;
        endcase
        return (p < 1) ? 1 : p;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic fb;
        fb = v[15] ^ v[13] ^ v[12] ^ v[10];
        return {v[14:0], fb};
    endfunction

    task automatic start_round(input logic [1:0] md);
        m_state  = 1;
        m_score  = 0;
        m_time   = GS;
        sec_n    = 0;
        mole_n   = 0;
        mole_per = per_of(md);
    endtask

    always @(posedge clk) begin : model
        logic [N-1:0] tg;
        bit sf, mf, h, ms;
        if (rst) begin
            m_state = 0; m_score = 0; m_time = GS; m_moles = '0;
            m_hit = 0; m_miss = 0; m_lfsr = SEED; m_prev = bus.switches_i;
            sec_n = 0; mole_n = 0; mole_per = per_of(bus.mode_i);
            m_valid = 1;
        end else begin
            tg = bus.switches_i ^ m_prev;
            m_prev = bus.switches_i;
            sec_n++;
            sf = (sec_n % CLK) == 0;
            mole_n++;
            mf = (mole_n >= mole_per);
            if (mf) begin
                mole_n = 0;
                mole_per = per_of(bus.mode_i);
            end
            m_hit = 0; m_miss = 0;
            case (m_state)
                0: begin
                    m_moles = '0; m_time = GS;
                    if (bus.start_i && bus.mode_i != 2'b00) start_round(bus.mode_i);
                end
                1: begin
                    if (bus.mode_i == 2'b00) begin
                        m_state = 0; m_moles = '0; m_time = GS;
                    end else begin
                        h  = (tg & m_moles) != '0;
                        ms = !h && (tg != '0);
                        m_hit = h; m_miss = ms;
                        if (h && m_score < SMAX) m_score++;
                        else if (ms && PEN == 1 && m_score > 0) m_score--;
                        if (mf) begin
                            m_lfsr  = lfsr_step(m_lfsr);
                            m_moles = '0;
                            m_moles[m_lfsr[$clog2(N)-1:0]] = 1'b1;
                        end else if (h) begin
                            m_moles = '0;
                        end
                        if (sf) begin
                            m_time--;
                            if (m_time == 0) begin
                                m_state = 2; m_moles = '0;
                            end
                        end
                    end
                end
                default: begin
                    m_moles = '0; m_time = 0;
                    if (bus.mode_i == 2'b00) begin
                        m_state = 0; m_time = GS;
                    end else if (bus.start_i) begin
                        start_round(bus.mode_i);
                    end
                end
            endcase
        end
    end

    // Every cycle after the first reset edge, all outputs must match the model
    always @(negedge clk) begin
        if (m_valid) begin
            chk("state",     32'(bus.state_o),     32'(m_state));
            chk("score",     32'(bus.score_o),     32'(m_score));
            chk("time_left", 32'(bus.time_left_o), 32'(m_time));
            chk("moles",     32'(bus.moles_o),     32'(m_moles));
            chk("hit",       32'(bus.hit_o),       32'(m_hit));
            chk("miss",      32'(bus.miss_o),      32'(m_miss));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic flip(input logic [N-1:0] m);
        bus.switches_i = bus.switches_i ^ m;
    endtask

    task automatic go(input logic [1:0] md);
        bus.mode_i  = md;
        bus.start_i = 1'b1;
        cyc(1);
        bus.start_i = 1'b0;
    endtask

    // Wait (bounded) until the model shows a lit mole, then whack it
    task automatic whack_next;
        bit found;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_moles != '0) found = 1;
            else cyc(1);
        end
        chk("mole_wait", 32'(found), 32'd1);
        flip(m_moles);
        cyc(1);
    endtask

    initial begin
        rst = 1'b1;
        bus.mode_i = 2'b00;
        bus.start_i = 1'b0;
        bus.switches_i = '0;
        cyc(3);
        chk("rst_state", 32'(bus.state_o), 32'd0);
        chk("rst_score", 32'(bus.score_o), 32'd0);
        chk("rst_time",  32'(bus.time_left_o), 32'd6);
        chk("rst_moles", 32'(bus.moles_o), 32'd0);
        rst = 1'b0;
        cyc(1);

        // Start with mode off is ignored
        go(2'b00);
        chk("idle_off_start", 32'(bus.state_o), 32'd0);

        // Round 1, slow mode
        go(2'b01);
        chk("run_entry", 32'(bus.state_o), 32'd1);
        cyc(2);
        flip(8'h01);                       // cycle 2: nothing lit, a miss
        cyc(1);
        chk("miss_floor_pulse", 32'(bus.miss_o), 32'd1);
        chk("miss_floor_score", 32'(bus.score_o), 32'd0);
        cyc(7);                            // cycle 10
        chk("first_mole", 32'(bus.moles_o), 32'h08);
        chk("time_at_10", 32'(bus.time_left_o), 32'd5);
        cyc(2);
        flip(8'h08);                       // cycle 12
        cyc(1);
        chk("hit_pulse", 32'(bus.hit_o), 32'd1);
        chk("hit_score", 32'(bus.score_o), 32'd1);
        chk("hit_clears", 32'(bus.moles_o), 32'd0);
        bus.start_i = 1'b1;                // start while running is ignored
        cyc(1);
        bus.start_i = 1'b0;
        cyc(15);                           // cycle 29: toggle lit mole as mole_tick fires
        flip(m_moles);
        cyc(1);
        chk("hit_on_tick", 32'(bus.hit_o), 32'd1);
        chk("hit_on_tick_score", 32'(bus.score_o), 32'd2);
        chk("new_mole_shown", 32'(bus.moles_o), 32'h80);
        flip(8'h06);                       // two unlit switches together
        cyc(1);
        chk("double_miss", 32'(bus.miss_o), 32'd1);
        chk("double_miss_score", 32'(bus.score_o), 32'd1);
        bus.mode_i = 2'b11;                // faster moles after current lap
        whack_next();
        whack_next();
        whack_next();
        chk("saturate_hit", 32'(bus.hit_o), 32'd1);
        chk("saturate_score", 32'(bus.score_o), 32'd3);
        bus.mode_i = 2'b00;                // abort
        cyc(1);
        chk("abort_state", 32'(bus.state_o), 32'd0);
        chk("abort_score", 32'(bus.score_o), 32'd3);
        chk("abort_moles", 32'(bus.moles_o), 32'd0);
        flip(8'h10);                       // ignored in IDLE
        cyc(2);

        // Round 2, run to completion
        go(2'b01);
        chk("r2_score_clear", 32'(bus.score_o), 32'd0);
        cyc(59);
        chk("r2_time_59", 32'(bus.time_left_o), 32'd1);
        cyc(1);
        chk("r2_over_state", 32'(bus.state_o), 32'd2);
        chk("r2_over_time", 32'(bus.time_left_o), 32'd0);
        chk("r2_over_moles", 32'(bus.moles_o), 32'd0);
        flip(8'h03);                       // ignored in OVER
        cyc(2);

        // Round 3 from OVER, reset mid-round while switches toggle
        go(2'b10);
        chk("r3_entry", 32'(bus.state_o), 32'd1);
        cyc(5);
        rst = 1'b1;
        flip(8'h21);
        cyc(1);
        chk("mid_rst_state", 32'(bus.state_o), 32'd0);
        chk("mid_rst_time", 32'(bus.time_left_o), 32'd6);
        chk("mid_rst_score", 32'(bus.score_o), 32'd0);
        flip(8'h42);
        cyc(1);
        rst = 1'b0;
        cyc(1);
        chk("post_rst_hit", 32'(bus.hit_o), 32'd0);
        chk("post_rst_miss", 32'(bus.miss_o), 32'd0);

        // Round 4, fast mode: hit on the final second tick
        go(2'b11);
        cyc(59);
        flip(m_moles);
        cyc(1);
        chk("final_tick_hit", 32'(bus.hit_o), 32'd1);
        chk("final_tick_state", 32'(bus.state_o), 32'd2);
        chk("final_tick_score", 32'(bus.score_o), 32'd1);
        bus.mode_i = 2'b00;                // OVER with mode off returns to IDLE
        cyc(1);
        chk("over_to_idle", 32'(bus.state_o), 32'd0);
        chk("over_to_idle_time", 32'(bus.time_left_o), 32'd6);
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/whack_game_ctrl.md
Name: whack_game_ctrl

Overview:
Parametrised whack-a-mole game engine that replaces the fixed 16-LED, 1/2/5 Hz game datapath with one configurable core.
- Generates its own second and mole-rate ticks from the system clock.
- Runs the IDLE/RUN/OVER game state machine and places moles pseudo-randomly.
- Detects switch whacks and keeps a saturating score.
- Sits between mode selection/switch inputs and the BCD/seven-segment display path, which consumes score_o and time_left_o.

Parameters:
N_MOLES, 16, number of mole LEDs/switches; legal values 4, 8, 16 (power of two)
CLK_HZ, 100000000, clock_i frequency; benches use 10
GAME_SECONDS, 60, round length in seconds, 1..255
SCORE_MAX, 9999, score saturation value (fits 4-digit display)
PENALTY, 1, 1 = a miss decrements score (floor 0); 0 = misses only pulse miss_o
LFSR_SEED, 16'hACE1, non-zero reset value of the 16-bit placement LFSR

Ports:
clock_i  in  1  system clock
reset_i  in  1  synchronous, active-high reset
mode_i  in  2  00 off, 01 slow (1 mole/s), 10 medium (2/s), 11 fast (5/s)
start_i  in  1  single-cycle start pulse (debounced upstream)
switches_i  in  N_MOLES  slide switches, already synchronised to clock_i
moles_o  out  N_MOLES  lit mole LEDs, one-hot or zero
score_o  out  14  current score, binary
time_left_o  out  8  seconds remaining, binary
state_o  out  2  00 IDLE, 01 RUN, 10 OVER
hit_o  out  1  one-cycle pulse per credited hit
miss_o  out  1  one-cycle pulse per miss cycle

Behaviour:
- Reset values: state_o = IDLE, moles_o = 0, score_o = 0, time_left_o = GAME_SECONDS, hit_o = miss_o = 0.
- Reset state: LFSR = LFSR_SEED; tick counters = 0; the previous-switch register loads switches_i, so no toggle is seen after reset.
- Tick generation: sec_tick every CLK_HZ cycles.
- Mole tick periods by mode: CLK_HZ (01), CLK_HZ/2 (10), CLK_HZ/5 (11), integer division.
- Both tick counters clear synchronously on entry to RUN. The first sec_tick and the first mole_tick fire one full period after entry.
- IDLE:
  - moles_o = 0; time_left_o = GAME_SECONDS; score_o holds the last value.
  - start_i with mode_i != 00 -> RUN next cycle; score cleared; time reloaded.
  - start_i with mode_i == 00 is ignored.
- RUN, mole placement: on mole_tick, the LFSR (taps 16,14,13,11) advances. moles_o becomes one-hot at index = low log2(N_MOLES) bits of the new LFSR value. A repeat index re-arms the same mole.
- RUN, time: on sec_tick, time_left decrements. If the decrement takes it to 0, the state goes to OVER on the same edge and moles_o clears.
- Whack detection:
  - toggle = switches_i XOR prev_switches; either direction counts.
  - prev_switches updates every cycle in all states.
  - Toggles in IDLE and OVER are ignored.
- Hit, in RUN:
  - Hit = any toggle at the lit mole's index.
  - Effects, registered one cycle after the toggle is sampled: hit_o pulses; score +1, saturating at SCORE_MAX; moles_o clears until the next mole_tick (one hit per mole).
- Miss, in RUN:
  - Miss = toggle(s) only on unlit positions.
  - Effects: miss_o pulses; if PENALTY = 1, score -1 with floor 0.
  - Several misses in one cycle count as one.
  - A hit and a miss in the same cycle count as a hit only.
- Simultaneous events:
  - Hit and mole_tick in the same cycle: hit is credited against the old mole; the new mole is displayed.
  - Hit and final sec_tick in the same cycle: hit is credited; state goes to OVER.
- Mode change in RUN: 01/10/11 -> the new rate applies from the next tick-counter wrap. 00 -> abort to IDLE next cycle, score retained, moles cleared.
- OVER: moles_o = 0, time_left_o = 0, score frozen. start_i with mode != 00 -> RUN (new round). mode_i == 00 -> IDLE.
- start_i in RUN is ignored.
- reset_i mid-round forces all reset values on the next edge, regardless of the other inputs.
- All outputs are registered; no combinational input-to-output paths.

Decomposition:
- Package whack_pkg holds: the state encoding (IDLE/RUN/OVER), mode codes, rate divisors (1, 2, 5), and the LFSR tap constant.
- Sub-module tick_gen: parametrised modulo counter with sync clear and a runtime period input, emitting a one-cycle tick. Instantiated twice: seconds and mole rate.

Test Plan:
1. CLK_HZ=10, GAME_SECONDS=3, mode 01, pulse start -> state_o=01 next cycle; time_left_o 3->2->1->0 at cycles 10/20/30 after entry; state_o=10 at cycle 30; moles_o=0 after.
2. Mode 01, first mole lit at cycle 10 at index k; toggle switch k at cycle 12 -> hit_o pulse at cycle 13; score_o=1; moles_o=0 until cycle 20.
3. PENALTY=1, score 0, toggle an unlit switch -> miss_o pulse; score stays 0. At score 2, toggle two unlit switches in one cycle -> score 1.
4. Lit switch toggled in the same cycle as a mole_tick -> hit credited; the new one-hot mole is shown. Force score=9998, then two hits -> 9999, 9999.
5. Mode 11 mid-round -> mole period becomes 2 cycles after the current counter wraps. Mode 00 mid-round -> state IDLE, score retained, moles_o=0.
6. reset_i asserted mid-round while switches are toggling -> all reset values next edge; no hit_o/miss_o on the first cycle after reset release.
